serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_fs_cell.sv | 13 +
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes iA - iB LSB first, one bit per clock, fixed latency.
//
// state | meaning
// IDLE  | waiting for iStart; outputs hold last result
// RUN   | one operand bit per cycle through fs_cell
// DONE  | single-cycle oDone pulse, then back to IDLE
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oD,
  output logic             oBorrow,
  output logic             oBusy,
  output logic             oDone
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic             bw;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] sh_d_next;

  fs_cell u_fs_cell (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .bin (bw),
    .d   (bit_d),
    .bout(bit_bout)
  );

  // The last bit is merged here so oD can load the complete result on the final RUN edge.
  assign sh_d_next = {bit_d, sh_d[WIDTH-1:1]};

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      sh_d    <= '0;
      bw      <= 1'b0;
      cnt     <= '0;
      oD      <= '0;
      oBorrow <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            sh_a  <= iA;
            sh_b  <= iB;
            sh_d  <= '0;
            bw    <= 1'b0;
            cnt   <= '0;
            oBusy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_d <= sh_d_next;
          bw   <= bit_bout;
          cnt  <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            oD      <= sh_d_next;
            oBorrow <= bit_bout;
            oDone   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors plus a random sweep.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic [WIDTH-1:0] d;
  logic             borrow;
  logic             busy;
  logic             done;

  int cyc   = 0;
  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             borrow;
    int               cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iStart (start),
    .iA     (a),
    .iB     (b),
    .oD     (d),
    .oBorrow(borrow),
    .oBusy  (busy),
    .oDone  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Start is accepted on the next edge; the done pulse is expected after WIDTH more edges.
  task automatic do_start(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input bit push, input logic [WIDTH-1:0] ed, input logic eb);
    exp_t e;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    if (push) begin
      e.d      = ed;
      e.borrow = eb;
      e.cyc    = cyc + WIDTH;
      q.push_back(e);
    end
  endtask

  task automatic idle_wait();
    repeat (WIDTH + 1) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_done: oDone=1 at edge %0d, required no pulse", cyc);
      end else begin
        mon_e = q.pop_front();
        check("result_d", 32'(d), 32'(mon_e.d));
        check("result_borrow", 32'(borrow), 32'(mon_e.borrow));
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    // Reset held with start asserted: reset must win.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check("reset_d", 32'(d), 32'h0);
    check("reset_borrow", 32'(borrow), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    start = 1'b0;

    do_start(8'h5A, 8'h3C, 1'b1, 8'h1E, 1'b0);
    for (int i = 1; i <= WIDTH + 2; i++) begin
      @(negedge clk);
      check("busy_profile", 32'(busy), (i <= WIDTH + 1) ? 32'h1 : 32'h0);
    end

    do_start(8'h00, 8'h01, 1'b1, 8'hFF, 1'b1);
    idle_wait();
    do_start(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
    idle_wait();

    // Start pulse during RUN must be ignored.
    do_start(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_d_during_run", 32'(d), 32'h00);
    start = 1'b1;
    a     = 8'h00;
    b     = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Reset mid-RUN aborts with no done pulse.
    do_start(8'h80, 8'h01, 1'b0, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_d", 32'(d), 32'h0);
    check("abort_borrow", 32'(borrow), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    do_start(8'h03, 8'h05, 1'b1, 8'hFE, 1'b1);
    idle_wait();

    // Back-to-back issue; oD holds the first result until the second pulse.
    do_start(8'h20, 8'h10, 1'b1, 8'h10, 1'b0);
    idle_wait();
    do_start(8'h01, 8'h02, 1'b1, 8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("hold_d_between", 32'(d), 32'h10);
    check("hold_borrow_between", 32'(borrow), 32'h0);
    repeat (5) @(posedge clk);
    #1;

    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      do_start(ra, rb, 1'b1, WIDTH'(ra - rb), (ra < rb));
      idle_wait();
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
